// File: rtl/gray_fifo_pkg.sv
// Shared widths and helpers for the Gray-pointer FIFO controller.
package gray_fifo_pkg;

  localparam int MAX_ADDR_W = 12;

  // Pointers carry one wrap bit above the RAM address.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Occupancy must hold 0..DEPTH inclusive, so it needs the same extra bit.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Widest legal pointer; each instance narrows to ptr_w(ADDR_W) bits.
  typedef logic [MAX_ADDR_W:0] ptr_max_t;

endpackage

// File: rtl/gray_code.sv
// Binary <-> Gray converter; INVERT=0 maps binary to Gray, INVERT=1 maps Gray to binary.
module gray_code #(
  parameter int WIDTH  = 4,
  parameter bit INVERT = 1'b0
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  if (!INVERT) begin : g_bin2gray
    assign out_o = in_i ^ (in_i >> 1);
  end else begin : g_gray2bin
    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
      logic acc;
      out_o = '0;
      acc   = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        acc      = acc ^ in_i[i];
        out_o[i] = acc;
      end
    end
  end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller with registered Gray pointers for CDC consumers.
// Optional almost_full/almost_empty flags are built when GRAY_FIFO_ALMOST_EN is defined.
module gray_fifo_ctrl
  import gray_fifo_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef GRAY_FIFO_ALMOST_EN
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  output logic              almost_full,
  output logic              almost_empty,
`endif
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int PW = ptr_w(ADDR_W);
  typedef logic [PW-1:0] ptr_t;

  // Handshakes: a word moves on a write when wr_valid && wr_ready, and on a read
  // when rd_valid && rd_ready; both ready/valid outputs depend only on registered state.
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t wr_gray_q, wr_gray_d;
  ptr_t rd_gray_q, rd_gray_d;
  ptr_t count_q, count_d;
  logic push, pop;

  always_comb begin
    full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
               (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    wr_ready = !full;
    rd_valid = !empty;
    push     = wr_valid && !full && !flush;
    pop      = rd_valid && rd_ready && !flush;
    mem_we   = push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + ptr_t'(1);
        2'b01:   count_d = count_q - ptr_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Gray codes are taken from the next-state pointers so they move on the same edge.
  gray_code #(.WIDTH(PW), .INVERT(1'b0)) u_wr_gray (
    .in_i  (wr_ptr_d),
    .out_o (wr_gray_d)
  );

  gray_code #(.WIDTH(PW), .INVERT(1'b0)) u_rd_gray (
    .in_i  (rd_ptr_d),
    .out_o (rd_gray_d)
  );

`ifdef GRAY_FIFO_ALMOST_EN
  logic almost_full_q, almost_empty_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_gray_q      <= '0;
      rd_gray_q      <= '0;
      count_q        <= '0;
`ifdef GRAY_FIFO_ALMOST_EN
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
`endif
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_gray_q      <= wr_gray_d;
      rd_gray_q      <= rd_gray_d;
      count_q        <= count_d;
`ifdef GRAY_FIFO_ALMOST_EN
      almost_full_q  <= (count_d >= af_thresh);
      almost_empty_q <= (count_d <= ae_thresh);
`endif
    end
  end

`ifdef GRAY_FIFO_ALMOST_EN
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

  assign mem_waddr   = wr_ptr_q[ADDR_W-1:0];
  assign mem_raddr   = rd_ptr_q[ADDR_W-1:0];
  assign wr_ptr_gray = wr_gray_q;
  assign rd_ptr_gray = rd_gray_q;
  assign count       = count_q;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Self-checking bench for gray_fifo_ctrl at ADDR_W=2 (define GRAY_FIFO_ALMOST_EN to cover the almost flags).
module tb_gray_fifo_ctrl;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int NPTR   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic              wr_ready, rd_valid, mem_we, full, empty;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [ADDR_W:0]   wr_ptr_gray, rd_ptr_gray, count;
`ifdef GRAY_FIFO_ALMOST_EN
  logic [ADDR_W:0]   af_thresh = 3'd3, ae_thresh = 3'd1;
  logic              almost_full, almost_empty;
`endif

  gray_fifo_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef GRAY_FIFO_ALMOST_EN
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
`endif
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_raddr   (mem_raddr),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // ---------------- reference model / scoreboard ----------------
  // The FIFO is modelled as a queue of the RAM addresses written, plus running push/pop totals.
  logic [ADDR_W-1:0] exp_q[$];
  int n_push = 0;
  int n_pop  = 0;
  int gray_tab[NPTR] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    n_push = 0;
    n_pop  = 0;
  endtask

  task automatic check_state();
    chk("count", int'(count), exp_q.size());
    chk("full",  int'(full),  int'(exp_q.size() == DEPTH));
    chk("empty", int'(empty), int'(exp_q.size() == 0));
    chk("wr_gray", int'(wr_ptr_gray), gray_tab[n_push % NPTR]);
    chk("rd_gray", int'(rd_ptr_gray), gray_tab[n_pop % NPTR]);
`ifdef GRAY_FIFO_ALMOST_EN
    chk("almost_full",  int'(almost_full),  int'(exp_q.size() >= 3));
    chk("almost_empty", int'(almost_empty), int'(exp_q.size() <= 1));
`endif
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; drives inputs, checks combinational outputs,
  // advances one rising edge, checks registered state, and returns after the next falling edge.
  task automatic cycle(input logic wv, input logic rr, input logic fl, input bit ham_exact,
                       output logic we_s, output logic [ADDR_W-1:0] ra_s);
    logic do_push, do_pop;
    logic [ADDR_W:0] wg_prev, rg_prev;
    wr_valid = wv;
    rd_ready = rr;
    flush    = fl;
    #1;
    do_push = wv && (exp_q.size() < DEPTH) && !fl;
    do_pop  = rr && (exp_q.size() != 0) && !fl;
    chk("mem_we",   int'(mem_we),   int'(do_push));
    chk("wr_ready", int'(wr_ready), int'(exp_q.size() < DEPTH));
    chk("rd_valid", int'(rd_valid), int'(exp_q.size() != 0));
    chk("mem_waddr", int'(mem_waddr), n_push % DEPTH);
    if (exp_q.size() != 0) chk("mem_raddr", int'(mem_raddr), int'(exp_q[0]));
    we_s    = mem_we;
    ra_s    = mem_raddr;
    wg_prev = wr_ptr_gray;
    rg_prev = rd_ptr_gray;
    @(posedge clk);
    if (fl) model_clear();
    else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (do_push) begin
        exp_q.push_back(ADDR_W'(n_push % DEPTH));
        n_push++;
      end
    end
    #1;
    check_state();
    if (ham_exact) begin
      chk("wr_gray_ham", $countones(wg_prev ^ wr_ptr_gray), 1);
      chk("rd_gray_ham", $countones(rg_prev ^ rd_ptr_gray), 1);
    end else if (!fl) begin
      chk("wr_gray_ham_le1", int'($countones(wg_prev ^ wr_ptr_gray) <= 1), 1);
      chk("rd_gray_ham_le1", int'($countones(rg_prev ^ rd_ptr_gray) <= 1), 1);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic wv;
    logic rr;
    int   cnt;
    logic full;
    logic empty;
    logic we;
    int   raddr;  // -1: not checked
  } vec_t;

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[9];
    logic we_s;
    logic [ADDR_W-1:0] ra_s;

    // fill, blocked 5th push, then drain
    vecs[0] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, -1};
    vecs[1] = '{1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, -1};
    vecs[2] = '{1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, -1};
    vecs[3] = '{1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1, -1};
    vecs[4] = '{1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, -1};
    vecs[5] = '{1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1};
    vecs[7] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 2};
    vecs[8] = '{1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 3};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_state();
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_rd_valid", int'(rd_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].wv, vecs[i].rr, 1'b0, 1'b0, we_s, ra_s);
      chk("tbl_we",    int'(we_s),  int'(vecs[i].we));
      chk("tbl_count", int'(count), vecs[i].cnt);
      chk("tbl_full",  int'(full),  int'(vecs[i].full));
      chk("tbl_empty", int'(empty), int'(vecs[i].empty));
      if (vecs[i].raddr >= 0) chk("tbl_raddr", int'(ra_s), vecs[i].raddr);
    end
    chk("tbl_rd_valid_end", int'(rd_valid), 0);

    // steady push+pop at count 2: pointers wrap, every Gray step is one bit
    cycle(1'b1, 1'b0, 1'b0, 1'b0, we_s, ra_s);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, we_s, ra_s);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b1, we_s, ra_s);
      chk("stream_count", int'(count), 2);
    end

    // flush beats push/pop at count 3
    cycle(1'b1, 1'b0, 1'b0, 1'b0, we_s, ra_s);
    chk("pre_flush_count", int'(count), 3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, we_s, ra_s);
    chk("flush_we", int'(we_s), 0);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_wr_gray", int'(wr_ptr_gray), 0);

    // asynchronous reset between edges mid-burst
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, we_s, ra_s);
    chk("pre_rst_count", int'(count), 3);
    wr_valid = 1'b1;
    rd_ready = 1'b0;
    flush    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_state();
    chk("async_rst_waddr", int'(mem_waddr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, we_s, ra_s);
    chk("post_rst_first_we", int'(we_s), 1);
    chk("post_rst_count", int'(count), 1);

    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0), 1'b0, we_s, ra_s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
